// File: rtl/alu_pkg.sv
// Shared opcode map, command layout and dispatcher state encoding for the 16-bit multi-cycle ALU.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OP_W-1:0] OP_NAND = 4'h5;
  localparam logic [OP_W-1:0] OP_NOR  = 4'h6;
  localparam logic [OP_W-1:0] OP_XNOR = 4'h7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h8;
  localparam logic [OP_W-1:0] OP_DIV  = 4'h9;

  // ALU execution lengths for the multi-cycle ops
  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 9;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_WAIT_BUSY,
    ST_RESP
  } disp_state_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_DIV);
  endfunction

  function automatic logic is_multi(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: registered full, count-based empty, no fall-through (read data comes from storage only).
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    cnt_next;

  // A push while full is dropped even if a pop frees a slot in the same cycle
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    cnt_next = count;
    if (push_ok && !pop_ok)
      cnt_next = count + CW'(1);
    else if (pop_ok && !push_ok)
      cnt_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= cnt_next;
      full  <= (cnt_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_dispatch.sv
// In-order, single-outstanding command front-end for the multi-cycle ALU: buffers commands,
// holds operands for the whole operation, and returns result+tag over a valid/ready port.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [15:0]            cmd_a,
  input  logic [15:0]            cmd_b,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [3:0]             alu_opcode,
  output logic                   alu_start,
  input  logic [15:0]            alu_result,
  input  logic                   alu_busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int FW   = $bits(alu_req_t) + TAG_W;
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  alu_req_t          push_req;
  alu_req_t          pop_req;
  alu_req_t          hold;
  logic [TAG_W-1:0]  pop_tag;
  logic [FW-1:0]     pop_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  disp_state_t       state;
  logic [WD_W-1:0]   wdog;

  assign push_req  = alu_req_t'{op: cmd_op, a: cmd_a, b: cmd_b};
  assign {pop_req, pop_tag} = pop_word;
  assign cmd_ready = !fifo_full;

  // Never pop while the ALU still reports busy from a previous op
  assign pop = (state == ST_IDLE) && !fifo_empty && !alu_busy;

  // ALU inputs come straight from the holding register, so they cannot move mid-op
  assign alu_a      = hold.a;
  assign alu_b      = hold.b;
  assign alu_opcode = hold.op;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({push_req, cmd_tag}),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold      <= '0;
      wdog      <= '0;
      alu_start <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            hold    <= pop_req;
            rsp_tag <= pop_tag;
            if (is_legal(pop_req.op)) begin
              alu_start <= 1'b1;
              state     <= ST_ISSUE;
            end else begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          alu_start <= 1'b0;
          wdog      <= '0;
          state     <= is_multi(hold.op) ? ST_WAIT_BUSY : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          rsp_data  <= alu_result;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_WAIT_BUSY: begin
          if (!alu_busy) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            // ALU hung: abort with an error rather than stall the queue forever
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural ALU, scoreboard of expected responses, directed and random traffic.
module tb_alu_dispatch;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [3:0]             cmd_op = '0;
  logic [15:0]            cmd_a = '0;
  logic [15:0]            cmd_b = '0;
  logic [TAG_W-1:0]       cmd_tag = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [15:0]            rsp_data;
  logic [TAG_W-1:0]       rsp_tag;
  logic                   rsp_err;
  logic [15:0]            alu_a;
  logic [15:0]            alu_b;
  logic [3:0]             alu_opcode;
  logic                   alu_start;
  logic [15:0]            alu_result;
  logic                   alu_busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic hang = 1'b0;

  always #5 clk = ~clk;

  alu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_busy(alu_busy), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a & b);
      4'h6: return ~(a | b);
      4'h7: return ~(a ^ b);
      4'h8: return a * b;
      4'h9: return (b == 16'h0) ? 16'h0 : a / b;
      default: return 16'h0;
    endcase
  endfunction

  function automatic exp_t expect_of(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [TAG_W-1:0] tag);
    exp_t e;
    e.tag = tag;
    if (op > 4'h9 || (hang && (op == 4'h8 || op == 4'h9))) begin
      e.data = 16'h0;
      e.err  = 1'b1;
    end else begin
      e.data = alu_ref(op, a, b);
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Behavioural ALU: single-cycle ops load the result at the start edge; MUL/DIV stay busy
  // for 5/9 cycles and read the operands at their final cycle. hang keeps busy stuck high.
  int unsigned m_left;
  logic [35:0] cap;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_busy   <= 1'b0;
      alu_result <= '0;
      m_left     <= 0;
      cap        <= '0;
    end else if (alu_start) begin
      cap <= {alu_opcode, alu_a, alu_b};
      if (alu_opcode == 4'h8 || alu_opcode == 4'h9) begin
        alu_busy <= 1'b1;
        m_left   <= (alu_opcode == 4'h8) ? 5 : 9;
      end else begin
        alu_result <= alu_ref(alu_opcode, alu_a, alu_b);
      end
    end else if (alu_busy && !hang) begin
      if (m_left == 1) begin
        alu_busy   <= 1'b0;
        alu_result <= alu_ref(alu_opcode, alu_a, alu_b);
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(posedge clk) if (rst_n && alu_start) starts <= starts + 1;

  logic             prev_stall = 1'b0;
  logic [15:0]      p_data;
  logic [TAG_W-1:0] p_tag;
  logic             p_err;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_hold_word", {43'd0, rsp_err, rsp_tag, rsp_data}, {43'd0, p_err, p_tag, p_data});
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(expect_of(cmd_op, cmd_a, cmd_b, cmd_tag));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_spurious", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
      if (alu_busy) chk("alu_operand_hold", 64'({alu_opcode, alu_a, alu_b}), 64'(cap));
      prev_stall <= rsp_valid && !rsp_ready;
      p_data     <= rsp_data;
      p_tag      <= rsp_tag;
      p_err      <= rsp_err;
    end
  end

  task automatic chk_reset(input string name);
    chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, "_rsp_word"}, 64'({rsp_err, rsp_tag, rsp_data}), 64'd0);
    chk({name, "_alu_ops"}, 64'({alu_opcode, alu_a, alu_b}), 64'd0);
    chk({name, "_alu_start"}, 64'(alu_start), 64'd0);
    chk({name, "_fifo_count"}, 64'(fifo_count), 64'd0);
  endtask

  // Called just after a rising edge; returns just after the accept edge with cmd_valid low.
  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_wait_expired", 64'(n >= 200), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_timed(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [TAG_W-1:0] tag, output int lat, output int npulse);
    int s0;
    int m = 0;
    s0 = starts;
    push(op, a, b, tag);
    forever begin
      @(negedge clk);
      if (rsp_valid || m >= 200) break;
      @(posedge clk);
      m++;
    end
    lat    = m + 1;
    npulse = starts - s0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_expired"}, 64'(n >= 3000), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   lat;
    int   np;
    int   n;
    int   sent;
    logic acc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_timed(4'h0, 16'h1234, 16'h0F0F, 4'd3, lat, np);
    chk("add_latency", 64'(lat), 64'd4);
    chk("add_start_pulses", 64'(np), 64'd1);

    send_timed(4'h8, 16'h0012, 16'h0034, 4'd1, lat, np);
    chk("mul_latency", 64'(lat), 64'd9);
    chk("mul_start_pulses", 64'(np), 64'd1);

    send_timed(4'h9, 16'h0064, 16'h0007, 4'd2, lat, np);
    chk("div_latency", 64'(lat), 64'd13);
    send_timed(4'h9, 16'h1234, 16'h0000, 4'd9, lat, np);
    chk("div0_latency", 64'(lat), 64'd13);

    send_timed(4'hC, 16'hAAAA, 16'h5555, 4'd7, lat, np);
    chk("illegal_latency", 64'(lat), 64'd2);
    chk("illegal_start_pulses", 64'(np), 64'd0);

    // Fill the FIFO behind a stalled response
    rsp_ready = 1'b0;
    push(4'h1, 16'h0100, 16'h0001, 4'd8);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("blocker_rsp_expired", 64'(n >= 50), 64'd0);
    for (int i = 0; i < 4; i++)
      push(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 4'(i));
    @(negedge clk);
    chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("full_count", 64'(fifo_count), 64'd4);
    @(posedge clk); #1;
    cmd_op = 4'h2; cmd_a = 16'hF0F0; cmd_b = 16'h3C3C; cmd_tag = 4'd4; cmd_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("full_hold_count", 64'(fifo_count), 64'd4);
      chk("full_hold_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fifth_accept_expired", 64'(n >= 50), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    drain("fifo_drain");
    @(negedge clk);
    chk("drained_count", 64'(fifo_count), 64'd0);
    @(posedge clk); #1;

    // Random traffic with response back-pressure
    acc  = 1'b0;
    sent = 0;
    for (int i = 0; i < 600; i++) begin
      if (!cmd_valid || acc) begin
        if (sent < 60 && $urandom_range(0, 9) < 6) begin
          cmd_op    = 4'($urandom_range(0, 15));
          cmd_a     = 16'($urandom);
          cmd_b     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
          cmd_tag   = 4'($urandom);
          cmd_valid = 1'b1;
          sent++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("random_drain");

    // Hung ALU: watchdog must abort with an error
    hang = 1'b1;
    send_timed(4'h8, 16'h0003, 16'h0004, 4'd5, lat, np);
    checks++;
    assert (lat >= TIMEOUT && lat <= TIMEOUT + 8) else begin
      errors++;
      $error("FAIL timeout_latency observed=%0d expected=%0d..%0d", lat, TIMEOUT, TIMEOUT + 8);
    end
    chk("timeout_start_pulses", 64'(np), 64'd1);

    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("reset_after_timeout");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a long op with commands still queued
    push(4'h8, 16'h0011, 16'h0022, 4'd5);
    push(4'h0, 16'h0001, 16'h0002, 4'd6);
    push(4'h4, 16'h00FF, 16'h0F0F, 4'd7);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_count", 64'(fifo_count), 64'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("reset_mid_wait");
    hang = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_timed(4'h7, 16'h1357, 16'h2468, 4'd11, lat, np);
    chk("post_reset_latency", 64'(lat), 64'd4);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
